// File: rtl/pipelined_add_unit.sv
// pipelined_add_unit: credit-limited add/sub pipeline feeding an in-order result FIFO with valid/ack handshake
module pipelined_add_unit #(
  parameter int LATENCY = 3,
  parameter int OUT_DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        IssueValid,
  input  logic [15:0] IssueInst,
  input  logic [2:0]  IssueTag,
  input  logic [15:0] OpA,
  input  logic [15:0] OpB,
  output logic        IssueReady,
  output logic        Done,
  output logic [2:0]  DoneTag,
  output logic [15:0] DoneInst,
  output logic [15:0] Dout,
  input  logic        CdbAck,
  output logic [3:0]  InFlight
);
  localparam int AW = $clog2(OUT_DEPTH);
  logic [LATENCY-1:0] p_vld;
  logic [2:0]  p_tag [LATENCY];
  logic [15:0] p_inst [LATENCY];
  logic [15:0] p_res [LATENCY];
  logic [2:0]  f_tag [OUT_DEPTH];
  logic [15:0] f_inst [OUT_DEPTH];
  logic [15:0] f_res [OUT_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic acc, pop, wr;
  logic [15:0] res;
  always_comb begin
    IssueReady = Resetn & (InFlight < 4'(OUT_DEPTH));
    acc = IssueValid & IssueReady & (IssueTag != 3'd0);
    Done = Resetn & (cnt != '0);
    pop = Done & CdbAck;
    wr = p_vld[LATENCY-1];
    res = IssueInst[3:0] == 4'd0 ? OpA + OpB : IssueInst[3:0] == 4'd1 ? OpA - OpB : OpA;
    DoneTag = Done ? f_tag[rp] : 3'd0;
    DoneInst = Done ? f_inst[rp] : 16'd0;
    Dout = Done ? f_res[rp] : 16'd0;
  end
  // payload needs no reset: the valid bits and FIFO count decide what is live
  always_ff @(posedge Clock) begin
    p_tag[0] <= IssueTag;
    p_inst[0] <= IssueInst;
    p_res[0] <= res;
    for (int i = 1; i < LATENCY; i++) begin
      p_tag[i] <= p_tag[i-1];
      p_inst[i] <= p_inst[i-1];
      p_res[i] <= p_res[i-1];
    end
    if (wr) begin
      f_tag[wp] <= p_tag[LATENCY-1];
      f_inst[wp] <= p_inst[LATENCY-1];
      f_res[wp] <= p_res[LATENCY-1];
    end
  end
  // credits bound pipeline+FIFO occupancy, so the FIFO can never overflow
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      p_vld <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      InFlight <= '0;
    end else begin
      p_vld[0] <= acc;
      for (int i = 1; i < LATENCY; i++) p_vld[i] <= p_vld[i-1];
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= (wr & ~pop) ? cnt + 1'b1 : (~wr & pop) ? cnt - 1'b1 : cnt;
      InFlight <= (acc & ~pop) ? InFlight + 4'd1 : (~acc & pop) ? InFlight - 4'd1 : InFlight;
    end
  end
endmodule

// File: tb/tb_pipelined_add_unit.sv
// tb_pipelined_add_unit: scenario tasks plus a credit model and result scoreboard
module tb_pipelined_add_unit;
  logic Clock = 0, Resetn = 0, IssueValid = 0, CdbAck = 0;
  logic [15:0] IssueInst = 0, OpA = 0, OpB = 0;
  logic [2:0] IssueTag = 0;
  logic IssueReady, Done;
  logic [2:0] DoneTag;
  logic [15:0] DoneInst, Dout;
  logic [3:0] InFlight;
  int vecs = 0, errs = 0, m_if = 0;
  logic [34:0] sb [$];

  pipelined_add_unit #(.LATENCY(3), .OUT_DEPTH(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .IssueValid(IssueValid), .IssueInst(IssueInst),
    .IssueTag(IssueTag), .OpA(OpA), .OpB(OpB), .IssueReady(IssueReady), .Done(Done),
    .DoneTag(DoneTag), .DoneInst(DoneInst), .Dout(Dout), .CdbAck(CdbAck), .InFlight(InFlight)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [15:0] calc(input logic [15:0] inst, input logic [15:0] a, input logic [15:0] b);
    case (inst[3:0])
      4'd0: return a + b;
      4'd1: return a - b;
      default: return a;
    endcase
  endfunction

  // model: credits, issue-order scoreboard, idle-bus zeros
  always @(negedge Clock) begin
    logic [34:0] e;
    vecs++;
    if (InFlight !== 4'(m_if)) begin
      errs++;
      $display("FAIL inflight got %0d exp %0d", InFlight, m_if);
    end
    vecs++;
    if (IssueReady !== (Resetn && m_if < 4)) begin
      errs++;
      $display("FAIL issue_ready got %b exp %b", IssueReady, (Resetn && m_if < 4));
    end
    if (!Done) begin
      vecs++;
      if ({DoneTag, DoneInst, Dout} !== 35'd0) begin
        errs++;
        $display("FAIL idle_bus got %h exp 0", {DoneTag, DoneInst, Dout});
      end
    end
    if (Done && CdbAck) begin
      vecs++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL unexpected_result got tag %0d dout %h exp none", DoneTag, Dout);
      end else begin
        e = sb.pop_front();
        if ({DoneTag, DoneInst, Dout} !== e) begin
          errs++;
          $display("FAIL result got %h exp %h", {DoneTag, DoneInst, Dout}, e);
        end
      end
    end
    if (!Resetn) begin
      m_if = 0;
      sb.delete();
    end else begin
      if (IssueValid && IssueTag != 0 && m_if < 4) begin
        m_if++;
        sb.push_back({IssueTag, IssueInst, calc(IssueInst, OpA, OpB)});
      end
      if (Done && CdbAck) m_if--;
    end
  end

  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    Resetn = 0;
    step;
    step;
    @(negedge Clock);
    vecs++;
    if ({Done, DoneTag, DoneInst, Dout, InFlight, IssueReady} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got %h exp 0", {Done, DoneTag, DoneInst, Dout, InFlight, IssueReady});
    end
    step;
    Resetn = 1;
    step;
    @(negedge Clock);
    vecs++;
    if (IssueReady !== 1'b1) begin
      errs++;
      $display("FAIL reset_release_ready got %b exp 1", IssueReady);
    end
  endtask

  task automatic test_basic;
    step;
    IssueValid = 1; IssueTag = 1; IssueInst = 16'h0C80; OpA = 5; OpB = 7;
    step;
    IssueValid = 0;
    @(negedge Clock);
    vecs++;
    if (Done !== 1'b0) begin
      errs++;
      $display("FAIL basic_early_k got %b exp 0", Done);
    end
    step;
    step;
    @(negedge Clock);
    vecs++;
    if (Done !== 1'b0) begin
      errs++;
      $display("FAIL basic_early_k2 got %b exp 0", Done);
    end
    step;
    @(negedge Clock);
    vecs++;
    if ({Done, DoneTag, DoneInst, Dout} !== {1'b1, 3'd1, 16'h0C80, 16'd12}) begin
      errs++;
      $display("FAIL basic_head got %h exp %h", {Done, DoneTag, DoneInst, Dout}, {1'b1, 3'd1, 16'h0C80, 16'd12});
    end
    step;
    CdbAck = 1;
    step;
    CdbAck = 0;
    @(negedge Clock);
    vecs++;
    if ({Done, InFlight} !== 5'd0) begin
      errs++;
      $display("FAIL basic_after_ack got %h exp 0", {Done, InFlight});
    end
  endtask

  task automatic test_wrap;
    logic [15:0] insts [3] = '{16'h0001, 16'h1400, 16'h0807};
    logic [15:0] as [3] = '{16'h0003, 16'hFFFF, 16'hBEEF};
    logic [15:0] bs [3] = '{16'h0005, 16'h0002, 16'h1234};
    logic [15:0] ex [3] = '{16'hFFFE, 16'h0001, 16'hBEEF};
    for (int i = 0; i < 3; i++) begin
      step;
      IssueValid = 1; IssueTag = 3'(i + 2); IssueInst = insts[i]; OpA = as[i]; OpB = bs[i];
      step;
      IssueValid = 0;
      step;
      step;
      step;
      @(negedge Clock);
      vecs++;
      if ({Done, Dout} !== {1'b1, ex[i]}) begin
        errs++;
        $display("FAIL wrap_%0d got %h exp %h", i, {Done, Dout}, {1'b1, ex[i]});
      end
      step;
      CdbAck = 1;
      step;
      CdbAck = 0;
    end
  endtask

  task automatic test_back_to_back;
    step;
    for (int t = 1; t <= 4; t++) begin
      IssueValid = 1; IssueTag = 3'(t); IssueInst = 16'(t << 10); OpA = 16'(t * 100); OpB = 16'(t);
      step;
    end
    IssueTag = 5;
    @(negedge Clock);
    vecs++;
    if ({IssueReady, InFlight, Done, DoneTag} !== {1'b0, 4'd4, 1'b1, 3'd1}) begin
      errs++;
      $display("FAIL b2b_full got %h exp %h", {IssueReady, InFlight, Done, DoneTag}, {1'b0, 4'd4, 1'b1, 3'd1});
    end
    for (int i = 0; i < 3; i++) begin
      step;
      @(negedge Clock);
      vecs++;
      if ({IssueReady, Done, DoneTag, Dout} !== {1'b0, 1'b1, 3'd1, 16'd101}) begin
        errs++;
        $display("FAIL b2b_stable got %h exp %h", {IssueReady, Done, DoneTag, Dout}, {1'b0, 1'b1, 3'd1, 16'd101});
      end
    end
    step;
    IssueValid = 0;
    CdbAck = 1;
    step;
    CdbAck = 0;
    @(negedge Clock);
    vecs++;
    if ({IssueReady, DoneTag} !== {1'b1, 3'd2}) begin
      errs++;
      $display("FAIL b2b_credit got %h exp %h", {IssueReady, DoneTag}, {1'b1, 3'd2});
    end
    step;
    CdbAck = 1;
    step;
    step;
    step;
    CdbAck = 0;
    @(negedge Clock);
    vecs++;
    if ({Done, InFlight} !== 5'd0) begin
      errs++;
      $display("FAIL b2b_drain got %h exp 0", {Done, InFlight});
    end
  endtask

  task automatic test_stream;
    step;
    CdbAck = 1;
    for (int i = 0; i < 24; i++) begin
      IssueValid = 1;
      IssueTag = 3'($urandom_range(1, 7));
      IssueInst = (16'($urandom) & 16'hFFF0) | 16'($urandom_range(0, 3));
      OpA = 16'($urandom);
      OpB = 16'($urandom);
      step;
    end
    IssueValid = 0;
    repeat (8) step;
    CdbAck = 0;
    @(negedge Clock);
    vecs++;
    if ({Done, InFlight} !== 5'd0 || sb.size() != 0) begin
      errs++;
      $display("FAIL stream_drain got %h left %0d exp 0", {Done, InFlight}, sb.size());
    end
  endtask

  task automatic test_ignore;
    step;
    IssueValid = 1; IssueTag = 0; IssueInst = 16'h0000; OpA = 16'h1111; OpB = 16'h2222;
    CdbAck = 1;
    repeat (3) step;
    @(negedge Clock);
    vecs++;
    if ({Done, InFlight} !== 5'd0) begin
      errs++;
      $display("FAIL ignore got %h exp 0", {Done, InFlight});
    end
    step;
    IssueValid = 0;
    CdbAck = 0;
  endtask

  task automatic test_mid_reset;
    step;
    for (int t = 1; t <= 4; t++) begin
      IssueValid = 1; IssueTag = 3'(t); IssueInst = 16'h0001; OpA = 16'(t * 7); OpB = 16'd1;
      step;
    end
    IssueValid = 0;
    @(negedge Clock);
    vecs++;
    if ({InFlight, Done} !== {4'd4, 1'b1}) begin
      errs++;
      $display("FAIL midrst_pre got %h exp %h", {InFlight, Done}, {4'd4, 1'b1});
    end
    step;
    Resetn = 0;
    step;
    Resetn = 1;
    @(negedge Clock);
    vecs++;
    if ({Done, DoneTag, DoneInst, Dout, InFlight} !== '0) begin
      errs++;
      $display("FAIL midrst_outputs got %h exp 0", {Done, DoneTag, DoneInst, Dout, InFlight});
    end
    step;
    CdbAck = 1;
    for (int i = 0; i < 8; i++) begin
      step;
      @(negedge Clock);
      vecs++;
      if (Done !== 1'b0) begin
        errs++;
        $display("FAIL midrst_ghost got %b exp 0", Done);
      end
    end
    step;
    CdbAck = 0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_back_to_back;
    test_stream;
    test_ignore;
    test_mid_reset;
    step;
    vecs++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL final_scoreboard got %0d pending exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
